// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator and
// the display logic that consumes its results.
package cmp_pkg;

    // Controller states: wait for a request, capture operands, then compare
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2
    } state_t;

    // Stored outcome of the last completed compare; RES_NONE until the first one
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_EQ   = 2'd1,
        RES_GT   = 2'd2,
        RES_LT   = 2'd3
    } result_t;

    // Active-low seven-segment patterns used by the downstream hex display
    localparam logic [7:0] SEG_E     = 8'b1000_0110;
    localparam logic [7:0] SEG_L     = 8'b1100_0111;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

endpackage

// File: rtl/magnitude_compare_seq_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, otherwise step up unless already at the ceiling
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/magnitude_compare_seq.sv
// Clocked magnitude comparator. A load request captures both operands and the
// signedness flag, the following cycle compares them, and the one-hot result,
// sticky valid flag, change pulse and per-outcome tallies are all registered.
module magnitude_compare_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 load,
    input  logic                 clear,
    output logic                 busy,
    output logic                 valid,
    output logic                 eq,
    output logic                 gt,
    output logic                 lt,
    output logic                 changed,
    output logic [CNT_WIDTH-1:0] eq_cnt,
    output logic [CNT_WIDTH-1:0] gt_cnt,
    output logic [CNT_WIDTH-1:0] lt_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic             opSigned_q;
    result_t          res_q;
    result_t          newRes;
    logic             valid_q;
    logic             changed_q;
    logic             changed_d;
    logic             captureEn;
    logic             compareDone;

    // State register; reset abandons any compare in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load is only honoured from IDLE, so requests while busy are dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = CAPTURE;
            CAPTURE: state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller outputs decoded from the current state
    always_comb begin
        busy        = (state_q != IDLE);
        captureEn   = (state_q == CAPTURE);
        compareDone = (state_q == COMPARE);
    end

    // Operand capture happens one cycle after the request, so input changes
    // around the load edge itself still reach the compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q      <= '0;
            opB_q      <= '0;
            opSigned_q <= 1'b0;
        end else if (captureEn) begin
            opA_q      <= a;
            opB_q      <= b;
            opSigned_q <= signed_mode;
        end
    end

    // Outcome of the captured operands; equality does not depend on signedness
    always_comb begin
        newRes = RES_LT;
        if (opA_q == opB_q) begin
            newRes = RES_EQ;
        end else if (opSigned_q) begin
            newRes = ($signed(opA_q) > $signed(opB_q)) ? RES_GT : RES_LT;
        end else begin
            newRes = (opA_q > opB_q) ? RES_GT : RES_LT;
        end
    end

    // Change pulse: only meaningful once a previous result exists, and clear suppresses it
    always_comb begin
        changed_d = compareDone && valid_q && (newRes != res_q) && !clear;
    end

    // Result, sticky valid and change pulse registers; clear leaves the result alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= RES_NONE;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
            if (compareDone) begin
                res_q   <= newRes;
                valid_q <= 1'b1;
            end
        end
    end

    assign valid   = valid_q;
    assign changed = changed_q;
    assign eq      = (res_q == RES_EQ);
    assign gt      = (res_q == RES_GT);
    assign lt      = (res_q == RES_LT);

    sat_counter #(.W(CNT_WIDTH)) uEqCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (compareDone && (newRes == RES_EQ)),
        .q    (eq_cnt)
    );

    sat_counter #(.W(CNT_WIDTH)) uGtCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (compareDone && (newRes == RES_GT)),
        .q    (gt_cnt)
    );

    sat_counter #(.W(CNT_WIDTH)) uLtCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (compareDone && (newRes == RES_LT)),
        .q    (lt_cnt)
    );

endmodule

// File: tb/tb_magnitude_compare_seq.sv
// Bench for magnitude_compare_seq with a narrow tally so saturation is reachable.
module tb_magnitude_compare_seq;

    localparam int W   = 4;
    localparam int CW  = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signedMode;
    logic          load;
    logic          clear;
    logic          busy;
    logic          valid;
    logic          eq;
    logic          gt;
    logic          lt;
    logic          changed;
    logic [CW-1:0] eqCnt;
    logic [CW-1:0] gtCnt;
    logic [CW-1:0] ltCnt;

    int compared;
    int mismatched;

    // Reference state: outcome 0 = none, 1 = eq, 2 = gt, 3 = lt
    int expRes;
    bit expValid;
    int expCnt [3];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [2:0]   expEqGtLt;
    } vec_t;

    vec_t vecs [9];

    magnitude_compare_seq #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .signed_mode(signedMode),
        .load       (load),
        .clear      (clear),
        .busy       (busy),
        .valid      (valid),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt),
        .changed    (changed),
        .eq_cnt     (eqCnt),
        .gt_cnt     (gtCnt),
        .lt_cnt     (ltCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int toValue(input logic [W-1:0] v, input bit s);
        int r;
        r = int'(v);
        if (s && (r >= (1 << (W - 1)))) r = r - (1 << W);
        return r;
    endfunction

    // Applies one completed compare to the reference; returns the expected change pulse
    function automatic bit modelCompare(input logic [W-1:0] va, input logic [W-1:0] vb,
                                        input bit s, input bit clr);
        int x;
        int y;
        int outcome;
        bit chg;
        x = toValue(va, s);
        y = toValue(vb, s);
        outcome = (x == y) ? 1 : ((x > y) ? 2 : 3);
        chg = expValid && !clr && (outcome != expRes);
        if (clr) begin
            for (int i = 0; i < 3; i++) expCnt[i] = 0;
        end else if (expCnt[outcome - 1] < CNT_MAX) begin
            expCnt[outcome - 1]++;
        end
        expRes = outcome;
        expValid = 1'b1;
        return chg;
    endfunction

    function automatic void modelReset();
        expRes = 0;
        expValid = 1'b0;
        for (int i = 0; i < 3; i++) expCnt[i] = 0;
    endfunction

    task automatic checkAll(input string tag, input bit expChg, input bit expBusy);
        checkOutput({tag, ".eq"}, int'(eq), int'(expRes == 1));
        checkOutput({tag, ".gt"}, int'(gt), int'(expRes == 2));
        checkOutput({tag, ".lt"}, int'(lt), int'(expRes == 3));
        checkOutput({tag, ".valid"}, int'(valid), int'(expValid));
        checkOutput({tag, ".changed"}, int'(changed), int'(expChg));
        checkOutput({tag, ".busy"}, int'(busy), int'(expBusy));
        checkOutput({tag, ".eq_cnt"}, int'(eqCnt), expCnt[0]);
        checkOutput({tag, ".gt_cnt"}, int'(gtCnt), expCnt[1]);
        checkOutput({tag, ".lt_cnt"}, int'(ltCnt), expCnt[2]);
    endtask

    // One full request: busy for two cycles, result at the third, pulse gone after
    task automatic applyStimulus(input string tag, input logic [W-1:0] va,
                                 input logic [W-1:0] vb, input bit s);
        bit chg;
        a = va;
        b = vb;
        signedMode = s;
        load = 1'b1;
        stepCycle();
        load = 1'b0;
        checkOutput({tag, ".busyN"}, int'(busy), 1);
        stepCycle();
        checkOutput({tag, ".busyN1"}, int'(busy), 1);
        stepCycle();
        chg = modelCompare(va, vb, s, 1'b0);
        checkAll(tag, chg, 1'b0);
        stepCycle();
        checkOutput({tag, ".changedAfter"}, int'(changed), 0);
    endtask

    task automatic clearPulse();
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) expCnt[i] = 0;
    endtask

    initial begin
        bit chg;
        compared = 0;
        mismatched = 0;
        modelReset();

        vecs[0] = '{a: 4'd5,  b: 4'd5,  s: 1'b0, expEqGtLt: 3'b100};
        vecs[1] = '{a: 4'd8,  b: 4'd7,  s: 1'b0, expEqGtLt: 3'b010};
        vecs[2] = '{a: 4'd8,  b: 4'd7,  s: 1'b1, expEqGtLt: 3'b001};
        vecs[3] = '{a: 4'd0,  b: 4'd15, s: 1'b0, expEqGtLt: 3'b001};
        vecs[4] = '{a: 4'd0,  b: 4'd15, s: 1'b1, expEqGtLt: 3'b010};
        vecs[5] = '{a: 4'd15, b: 4'd15, s: 1'b1, expEqGtLt: 3'b100};
        vecs[6] = '{a: 4'd7,  b: 4'd8,  s: 1'b1, expEqGtLt: 3'b010};
        vecs[7] = '{a: 4'd9,  b: 4'd3,  s: 1'b1, expEqGtLt: 3'b001};
        vecs[8] = '{a: 4'd3,  b: 4'd2,  s: 1'b0, expEqGtLt: 3'b010};

        rst_n = 1'b0;
        a = '0;
        b = '0;
        signedMode = 1'b0;
        load = 1'b0;
        clear = 1'b0;
        #12;
        checkAll("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        stepCycle();

        // First compare after reset: equal operands, no change pulse
        applyStimulus("eq55", 4'd5, 4'd5, 1'b0);
        checkOutput("eq55.eqCntConst", int'(eqCnt), 1);

        // Same bit pattern, unsigned then signed, must flip and pulse changed
        applyStimulus("u8v7", 4'b1000, 4'b0111, 1'b0);
        checkOutput("u8v7.gt", int'(gt), 1);
        applyStimulus("s8v7", 4'b1000, 4'b0111, 1'b1);
        checkOutput("s8v7.lt", int'(lt), 1);
        checkOutput("s8v7.gtCnt", int'(gtCnt), 1);
        checkOutput("s8v7.ltCnt", int'(ltCnt), 1);

        // Table vectors with hand-derived one-hot results
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s);
            checkOutput($sformatf("vec%0d.onehot", i), int'({eq, gt, lt}),
                        int'(vecs[i].expEqGtLt));
        end

        // Load held for six cycles: only edges 0 and 3 are accepted
        clearPulse();
        a = 4'd3;
        b = 4'd9;
        signedMode = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 6; i++) stepCycle();
        load = 1'b0;
        checkOutput("hold.busy", int'(busy), 0);
        checkOutput("hold.ltCnt", int'(ltCnt), 2);
        void'(modelCompare(4'd3, 4'd9, 1'b0, 1'b0));
        void'(modelCompare(4'd3, 4'd9, 1'b0, 1'b0));
        stepCycle();
        checkAll("hold", 1'b0, 1'b0);

        // Saturation of a 2-bit tally, then clear colliding with completion
        clearPulse();
        for (int i = 0; i < 5; i++) applyStimulus($sformatf("sat%0d", i), 4'd6, 4'd6, 1'b0);
        checkOutput("sat.eqCnt", int'(eqCnt), 3);
        a = 4'd6;
        b = 4'd6;
        load = 1'b1;
        stepCycle();
        load = 1'b0;
        stepCycle();
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        chg = modelCompare(4'd6, 4'd6, 1'b0, 1'b1);
        checkAll("clrDone", chg, 1'b0);
        checkOutput("clrDone.eqCnt", int'(eqCnt), 0);
        checkOutput("clrDone.eq", int'(eq), 1);

        // Reset while the controller is in CAPTURE
        applyStimulus("preRst", 4'd2, 4'd1, 1'b0);
        a = 4'd1;
        b = 4'd2;
        load = 1'b1;
        stepCycle();
        load = 1'b0;
        checkOutput("midRst.busyBefore", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("midRst", 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        stepCycle();
        stepCycle();
        checkAll("postRstIdle", 1'b0, 1'b0);
        applyStimulus("postRst", 4'd4, 4'd4, 1'b0);

        // Operand change between load edge and capture edge is used; later change is not
        a = 4'd1;
        b = 4'd2;
        signedMode = 1'b0;
        load = 1'b1;
        stepCycle();
        load = 1'b0;
        a = 4'd7;
        stepCycle();
        a = 4'd0;
        stepCycle();
        chg = modelCompare(4'd7, 4'd2, 1'b0, 1'b0);
        checkAll("lateA", chg, 1'b0);
        checkOutput("lateA.gt", int'(gt), 1);

        // Random compares against the reference, with occasional clears
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) clearPulse();
            applyStimulus($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/magnitude_compare_seq.md
# magnitude_compare_seq

Parametrised, clocked magnitude comparator. Captures two WIDTH-bit operands on a load strobe and compares them as unsigned or two's-complement. Holds a registered one-hot eq/gt/lt result and keeps saturating per-outcome tally counters. It sits between the board-level switch/key conditioning and the LEDR/HEX display logic, replacing the purely combinational 4-bit compare.

## Interface
- WIDTH, 4: operand width in bits (≥2).
- CNT_WIDTH, 8: width of each tally counter (≥2).
- clk  input  1  system clock (MAX10_CLK1_50 at board top).
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A (board: upper switch group).
- b  input  WIDTH  operand B (board: lower switch group).
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- load  input  1  single-cycle request to capture and compare; already debounced/edge-detected upstream.
- clear  input  1  synchronous clear of tally counters and the change flag.
- busy  output  1  high while a compare is in flight.
- valid  output  1  high once any compare has completed since reset; sticky.
- eq / gt / lt  output  1 each  registered result, one-hot when valid, all 0 before the first compare.
- changed  output  1  one-cycle pulse when a completed result differs from the previous one.
- eq_cnt / gt_cnt / lt_cnt  output  CNT_WIDTH each  saturating count of each outcome.

## Operation
- FSM states: IDLE, CAPTURE, COMPARE.
  - IDLE: load=1 → CAPTURE; otherwise stay.
  - CAPTURE: register a, b, signed_mode into op_a, op_b, op_signed → COMPARE.
  - COMPARE: compute the result from the registered operands; update eq/gt/lt, valid, counters and changed → IDLE.
- busy = (state != IDLE). load while busy is ignored, not queued.
- Compare rule: gt means A > B. Signed mode uses the MSB as sign, e.g. WIDTH=4: 4'b1000 (−8) < 4'b0111 (+7). Unsigned mode gives the opposite for the same pair.
- Counters: the counter for the outcome increments by 1 per completed compare and saturates at all-ones, with no wrap.
- clear in any state: all three counters go to 0 and changed is forced to 0 that cycle; eq/gt/lt and valid are unaffected.
- clear and COMPARE completion in the same cycle: clear wins. Counters read 0 afterwards, but eq/gt/lt still update.
- changed fires only if valid was already 1 before this compare. The first compare after reset never pulses changed.

## Timing
- Reset values: state=IDLE, busy=0, valid=0, eq=gt=lt=0, changed=0, all counters 0, operand registers 0.
- Latency: load sampled high at edge N → busy=1 after N. Operands are captured at edge N+1. Result, counters and changed update at edge N+2. busy=0 after N+2.
- Back-to-back: the earliest accepted next load is sampled at edge N+3. Throughput is one compare per 3 cycles.
- a/b/signed_mode only matter at edge N+1; changes at edges N or N+2 do not affect that compare.
- Reset asserted mid-operation: everything returns immediately and asynchronously to reset values. The in-flight compare is discarded and counts nothing.
- changed is high for exactly one cycle, coincident with the result update.

## Structure
- Package cmp_pkg:
  - state enum (IDLE/CAPTURE/COMPARE).
  - result enum (RES_NONE/RES_EQ/RES_GT/RES_LT).
  - active-low HEX constants for display use: SEG_E = 8'b1000_0110, SEG_L = 8'b1100_0111, SEG_BLANK = 8'b1111_1111.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, clr, inc; output q): instantiated three times.
- Segment decoding stays outside this block in the existing hex-decoder module.

## Test plan
- Reset, then WIDTH=4, unsigned, a=5, b=5, load pulse → two cycles later eq=1, valid=1, eq_cnt=1, changed=0, busy high for exactly 2 cycles.
- Unsigned a=4'b1000, b=4'b0111 → gt=1; repeat with signed_mode=1 → lt=1 and changed pulses one cycle; gt_cnt=1, lt_cnt=1.
- load held high for 6 cycles with a=3, b=9 → exactly 2 compares accepted (edges 0 and 3), lt_cnt=2.
- CNT_WIDTH=2, five eq compares → eq_cnt saturates at 3; then clear coincident with a sixth completion → eq_cnt=0, eq=1.
- rst_n dropped during CAPTURE → all outputs 0 immediately; next load completes a normal compare with changed=0.
- a changed one cycle after load, before edge N+1 → result reflects the new value; a changed at N+2 → result unaffected.
